alarm_control: RTL and testbench
================================

# alarm_control

Alarm sequencer for the 24-hour clock/alarm design. Compares the running clock time against the stored alarm time once per minute, drives the ring output, and manages stop, snooze and ring timeout, using the shared one-second tick as its only time base. Sits beside the hour/minute set controllers, reads the clock and alarm counter values, and feeds the buzzer/LED driver.

## Interface

Parameters:
- RING_SECONDS, 60, ring duration before automatic silence; legal 1..4095
- SNOOZE_MINUTES, 5, snooze interval; legal 1..60

Ports:
- ck  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; forces all state and outputs to reset values immediately
- sec_tick  in  1  one-cycle pulse per second, synchronous to ck
- clk_hh  in  5  clock hours 0..23
- clk_mm  in  6  clock minutes 0..59
- clk_ss  in  6  clock seconds 0..59
- al_hh  in  5  alarm hours 0..23
- al_mm  in  6  alarm minutes 0..59
- alarm_en  in  1  level; alarm armed when 1
- snooze  in  1  button level, synchronous to ck
- stop  in  1  button level, synchronous to ck
- ring  out  1  1 while in RING
- snoozing  out  1  1 while in SNOOZE
- alarm_event  out  1  one-cycle pulse on IDLE->RING

## Operation

- Match condition: clk_hh==al_hh && clk_mm==al_mm && clk_ss==0. Registered match_q; trigger = match & ~match_q (single cycle per matching minute).
- Button edges: snooze_q, stop_q registered; snooze_p = snooze & ~snooze_q, stop_p = stop & ~stop_q. Held buttons act once.
- Counter cnt: 12-bit unsigned down-counter, decremented only on sec_tick; never wraps below 0.
- States: IDLE, RING, SNOOZE (2-bit encoding).
- IDLE: trigger && alarm_en -> RING, cnt <= RING_SECONDS, alarm_event pulse. Otherwise stay.
- RING (priority top-down): !alarm_en or stop_p -> IDLE; snooze_p -> SNOOZE, cnt <= SNOOZE_MINUTES*60; sec_tick && cnt==1 -> IDLE (timeout); sec_tick -> cnt <= cnt-1. Trigger ignored.
- SNOOZE (priority top-down): !alarm_en or stop_p -> IDLE; sec_tick && cnt==1 -> RING, cnt <= RING_SECONDS (no alarm_event); sec_tick -> cnt <= cnt-1. snooze_p and trigger ignored.
- Snooze may be repeated without limit; each RING re-entry reloads full RING_SECONDS.
- Simultaneous stop_p and snooze_p: stop wins. Simultaneous stop_p/snooze_p with timeout tick: button wins.
- Illegal state encoding -> IDLE on next edge.
- Alarm time change during SNOOZE does not affect the snooze countdown.

## Timing

- Reset values: state IDLE, cnt 0, match_q/snooze_q/stop_q 0, ring 0, snoozing 0, alarm_event 0.
- ring/snoozing decoded from state register: change the cycle after the deciding edge (latency 1 cycle from trigger/button/tick sampling).
- alarm_event high exactly one cycle, coincident with first ring cycle.
- Ring duration: ring stays high for exactly RING_SECONDS sec_tick pulses; falls after the RING_SECONDS-th tick.
- Snooze duration: exactly SNOOZE_MINUTES*60 sec_tick pulses in SNOOZE, then ring re-asserts.
- Reset asserted mid-RING or mid-SNOOZE: outputs 0 immediately (asynchronous); after release, no ring until the next fresh trigger.
- Match present at reset release: match_q starts 0, so a match condition already true at release triggers once.
- alarm_en low at trigger cycle: no ring, no event; raising alarm_en later in the same second does not ring (trigger already consumed).

## Test plan

- al=07:30, alarm_en=1, clock steps 07:29:59 -> 07:30:00: ring and alarm_event rise one cycle after match edge; alarm_event width 1 cycle.
- RING_SECONDS=4, no buttons: ring high for exactly 4 sec_ticks, then IDLE; no retrigger during rest of 07:30.
- Ringing, snooze pulse, SNOOZE_MINUTES=1: snoozing=1, ring=0 for 60 ticks; then ring=1, alarm_event stays 0; snooze held high throughout acts once.
- Ringing, stop and snooze asserted same cycle: -> IDLE, ring=0, snoozing=0.
- In SNOOZE, alarm_en dropped to 0: -> IDLE next cycle; cnt reload not observed; re-enable gives no ring until next 07:30:00.
- reset low mid-RING with cnt=2: ring=0 asynchronously; after release, state IDLE, ring stays 0 with no trigger.

Source files
------------

// File: rtl/alarm_control_if.sv
// Signal bundle between the clock/alarm datapath and the alarm sequencer.
// The master side drives time, buttons and the one-second tick; the slave
// side (the sequencer) returns the ring/snooze status and the alarm event.
interface alarm_control_if;
  logic       sec_tick;
  logic [4:0] clk_hh;
  logic [5:0] clk_mm;
  logic [5:0] clk_ss;
  logic [4:0] al_hh;
  logic [5:0] al_mm;
  logic       alarm_en;
  logic       snooze;
  logic       stop;
  logic       ring;
  logic       snoozing;
  logic       alarm_event;

  modport master (
    output sec_tick, clk_hh, clk_mm, clk_ss, al_hh, al_mm,
    output alarm_en, snooze, stop,
    input  ring, snoozing, alarm_event
  );

  modport slave (
    input  sec_tick, clk_hh, clk_mm, clk_ss, al_hh, al_mm,
    input  alarm_en, snooze, stop,
    output ring, snoozing, alarm_event
  );
endinterface

// File: rtl/alarm_control.sv
// Alarm sequencer: detects the start of the alarm minute, rings for a fixed
// number of seconds, and handles stop, repeatable snooze and ring timeout.
// The one-second tick is the only time base; one 12-bit down-counter serves
// both the ring and the snooze countdown.
module alarm_control #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic            ck,
  input  logic            reset,
  alarm_control_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  localparam logic [11:0] RING_LOAD   = 12'(RING_SECONDS);
  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MINUTES * 60);

  state_t      r_state;
  logic [11:0] r_cnt;
  logic        r_match_q;
  logic        r_snooze_q;
  logic        r_stop_q;
  logic        r_alarm_event;

  logic        w_match;
  logic        w_trigger;
  logic        w_snooze_p;
  logic        w_stop_p;
  logic        w_last_tick;

  // Match only at second zero of the alarm minute; the edge detect below
  // turns a held match into a single trigger per matching minute.
  assign w_match     = (bus.clk_hh == bus.al_hh) && (bus.clk_mm == bus.al_mm) &&
                       (bus.clk_ss == 6'd0);
  assign w_trigger   = w_match & ~r_match_q;
  assign w_snooze_p  = bus.snooze & ~r_snooze_q;
  assign w_stop_p    = bus.stop & ~r_stop_q;
  assign w_last_tick = bus.sec_tick && (r_cnt == 12'd1);

  // Sequencer state, countdown, input edge history and the event pulse.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 12'd0;
      r_match_q     <= 1'b0;
      r_snooze_q    <= 1'b0;
      r_stop_q      <= 1'b0;
      r_alarm_event <= 1'b0;
    end else begin
      r_match_q     <= w_match;
      r_snooze_q    <= bus.snooze;
      r_stop_q      <= bus.stop;
      r_alarm_event <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger && bus.alarm_en) begin
            r_state       <= ST_RING;
            r_cnt         <= RING_LOAD;
            r_alarm_event <= 1'b1;
          end
        end
        ST_RING: begin
          // Buttons outrank the timeout tick; stop outranks snooze.
          if (!bus.alarm_en || w_stop_p) begin
            r_state <= ST_IDLE;
          end else if (w_snooze_p) begin
            r_state <= ST_SNOOZE;
            r_cnt   <= SNOOZE_LOAD;
          end else if (w_last_tick) begin
            r_state <= ST_IDLE;
            r_cnt   <= 12'd0;
          end else if (bus.sec_tick && (r_cnt != 12'd0)) begin
            r_cnt <= r_cnt - 12'd1;
          end
        end
        ST_SNOOZE: begin
          // Re-entering RING reloads the full ring time but is not a new event.
          if (!bus.alarm_en || w_stop_p) begin
            r_state <= ST_IDLE;
          end else if (w_last_tick) begin
            r_state <= ST_RING;
            r_cnt   <= RING_LOAD;
          end else if (bus.sec_tick && (r_cnt != 12'd0)) begin
            r_cnt <= r_cnt - 12'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ring        = (r_state == ST_RING);
  assign bus.snoozing    = (r_state == ST_SNOOZE);
  assign bus.alarm_event = r_alarm_event;

endmodule

// File: tb/tb_alarm_control.sv
// Directed bench for alarm_control with RING_SECONDS=4, SNOOZE_MINUTES=1.
// Expected {ring, snoozing, alarm_event} values are queued as each step is
// driven and popped when the DUT outputs are sampled on the falling edge.
module tb_alarm_control;
  localparam int RING_S = 4;
  localparam int SNZ_M  = 1;

  typedef struct {
    string      tag;
    logic [2:0] outs;
  } sb_t;

  logic ck    = 1'b0;
  logic reset = 1'b1;
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hh, mm, ss;

  alarm_control_if bus ();

  alarm_control #(
    .RING_SECONDS  (RING_S),
    .SNOOZE_MINUTES(SNZ_M)
  ) dut (
    .ck   (ck),
    .reset(reset),
    .bus  (bus)
  );

  always #5 ck = ~ck;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic drive_time();
    bus.clk_hh = 5'(hh);
    bus.clk_mm = 6'(mm);
    bus.clk_ss = 6'(ss);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hh = h; mm = m; ss = s;
    drive_time();
  endtask

  task automatic advance_time();
    ss = ss + 1;
    if (ss == 60) begin
      ss = 0;
      mm = mm + 1;
      if (mm == 60) begin
        mm = 0;
        hh = (hh + 1) % 24;
      end
    end
    drive_time();
  endtask

  task automatic cyc();
    @(posedge ck);
    @(negedge ck);
  endtask

  task automatic expect_out(input string tag, input logic r, input logic s, input logic e);
    sb_t it;
    it.tag  = tag;
    it.outs = {r, s, e};
    sb_q.push_back(it);
  endtask

  task automatic check_out();
    sb_t        it;
    logic [2:0] got;
    it  = sb_q.pop_front();
    got = {bus.ring, bus.snoozing, bus.alarm_event};
    checks++;
    assert (got === it.outs)
    else begin
      errors++;
      $error("FAIL %s ring/snoozing/alarm_event got %b expected %b", it.tag, got, it.outs);
    end
  endtask

  // One clock cycle with no tick, then compare.
  task automatic step_chk(input string tag, input logic r, input logic s, input logic e);
    expect_out(tag, r, s, e);
    cyc();
    check_out();
  endtask

  // One sec_tick cycle, compare, then the clock time advances by one second.
  task automatic sec_pulse(input string tag, input logic r, input logic s, input logic e);
    expect_out(tag, r, s, e);
    bus.sec_tick = 1'b1;
    cyc();
    check_out();
    bus.sec_tick = 1'b0;
    advance_time();
  endtask

  initial begin
    bus.sec_tick = 1'b0;
    bus.snooze   = 1'b0;
    bus.stop     = 1'b0;
    bus.alarm_en = 1'b1;
    bus.al_hh    = 5'd7;
    bus.al_mm    = 6'd30;
    set_time(7, 29, 58);

    // Reset state.
    #2 reset = 1'b0;
    #1 expect_out("rst_async", 1'b0, 1'b0, 1'b0);
    check_out();
    cyc();
    step_chk("in_reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step_chk("idle", 1'b0, 1'b0, 1'b0);

    // Basic trigger at 07:30:00 and ring timeout after 4 ticks.
    sec_pulse("pre_59", 1'b0, 1'b0, 1'b0);
    sec_pulse("pre_00", 1'b0, 1'b0, 1'b0);
    step_chk("trig", 1'b1, 1'b0, 1'b1);
    step_chk("ev_width", 1'b1, 1'b0, 1'b0);
    sec_pulse("ring_t1", 1'b1, 1'b0, 1'b0);
    sec_pulse("ring_t2", 1'b1, 1'b0, 1'b0);
    sec_pulse("ring_t3", 1'b1, 1'b0, 1'b0);
    sec_pulse("ring_timeout", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) sec_pulse("no_retrig", 1'b0, 1'b0, 1'b0);

    // Snooze held for the whole interval acts once; ring returns without event.
    set_time(7, 29, 59);
    cyc();
    sec_pulse("pre2", 1'b0, 1'b0, 1'b0);
    step_chk("trig2", 1'b1, 1'b0, 1'b1);
    bus.snooze = 1'b1;
    step_chk("snz_enter", 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= SNZ_M * 60; i++) begin
      if (i < SNZ_M * 60) sec_pulse("snz_cnt", 1'b0, 1'b1, 1'b0);
      else                sec_pulse("snz_end", 1'b1, 1'b0, 1'b0);
    end
    step_chk("snz_held_once", 1'b1, 1'b0, 1'b0);
    bus.snooze = 1'b0;
    step_chk("ring_hold", 1'b1, 1'b0, 1'b0);

    // Stop and snooze together: stop wins.
    bus.stop   = 1'b1;
    bus.snooze = 1'b1;
    step_chk("stop_wins", 1'b0, 1'b0, 1'b0);
    step_chk("idle_after_stop", 1'b0, 1'b0, 1'b0);
    bus.stop   = 1'b0;
    bus.snooze = 1'b0;
    cyc();

    // Snooze press on the timeout tick: button wins.
    set_time(7, 29, 59);
    cyc();
    sec_pulse("pre3", 1'b0, 1'b0, 1'b0);
    step_chk("trig3", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < RING_S - 1; i++) sec_pulse("ring3", 1'b1, 1'b0, 1'b0);
    bus.snooze = 1'b1;
    sec_pulse("snz_vs_timeout", 1'b0, 1'b1, 1'b0);
    bus.stop = 1'b1;
    step_chk("stop_in_snooze", 1'b0, 1'b0, 1'b0);
    bus.stop   = 1'b0;
    bus.snooze = 1'b0;
    cyc();

    // alarm_en dropped during snooze; countdown must not resume later.
    set_time(7, 29, 59);
    cyc();
    sec_pulse("pre4", 1'b0, 1'b0, 1'b0);
    step_chk("trig4", 1'b1, 1'b0, 1'b1);
    bus.snooze = 1'b1;
    step_chk("snz4", 1'b0, 1'b1, 1'b0);
    bus.snooze = 1'b0;
    for (int i = 0; i < 3; i++) sec_pulse("snz4_cnt", 1'b0, 1'b1, 1'b0);
    bus.alarm_en = 1'b0;
    step_chk("en_drop", 1'b0, 1'b0, 1'b0);
    bus.alarm_en = 1'b1;
    for (int i = 0; i < 65; i++) sec_pulse("no_ring_reen", 1'b0, 1'b0, 1'b0);

    // Disabled at the trigger cycle; enabling later in the same second is too late.
    bus.alarm_en = 1'b0;
    set_time(7, 29, 59);
    cyc();
    sec_pulse("pre5", 1'b0, 1'b0, 1'b0);
    step_chk("dis_trig", 1'b0, 1'b0, 1'b0);
    bus.alarm_en = 1'b1;
    step_chk("late_en", 1'b0, 1'b0, 1'b0);
    sec_pulse("late_en_sec", 1'b0, 1'b0, 1'b0);

    // Reset mid-ring with two seconds left.
    set_time(7, 29, 59);
    cyc();
    sec_pulse("pre6", 1'b0, 1'b0, 1'b0);
    step_chk("trig6", 1'b1, 1'b0, 1'b1);
    sec_pulse("ring6_t1", 1'b1, 1'b0, 1'b0);
    sec_pulse("ring6_t2", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #1 expect_out("rst_mid_ring", 1'b0, 1'b0, 1'b0);
    check_out();
    @(negedge ck);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) sec_pulse("post_rst", 1'b0, 1'b0, 1'b0);

    // Match already true when reset releases triggers exactly once.
    reset = 1'b0;
    set_time(7, 30, 0);
    cyc();
    reset = 1'b1;
    step_chk("rel_match", 1'b1, 1'b0, 1'b1);
    step_chk("rel_match_hold", 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
